// File: rtl/avmm_cfg_pkg.sv
// Shared types for the AVMM configuration master: command word and bus FSM states.
package avmm_cfg_pkg;

    localparam int AVMM_ADDR_W = 17;
    localparam int AVMM_DATA_W = 32;
    localparam int AVMM_BE_W   = AVMM_DATA_W / 8;

    typedef struct packed {
        logic                   write;
        logic [AVMM_ADDR_W-1:0] addr;
        logic [AVMM_BE_W-1:0]   be;
        logic [AVMM_DATA_W-1:0] wdata;
    } avmm_cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } avmm_bus_st_e;

endpackage

// File: rtl/avmm_cfg_cmd_fifo.sv
// Synchronous command FIFO; the head entry is read straight from the storage registers.
module avmm_cfg_cmd_fifo
    import avmm_cfg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  avmm_cmd_t push_data_i,
    input  logic      pop_i,
    output avmm_cmd_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    avmm_cmd_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/avmm_cfg_master.sv
// Avalon-MM config master: queues commands, issues one bus transfer per cycle,
// tracks pipelined reads and fails the oldest read after a silent timeout.
module avmm_cfg_master
    import avmm_cfg_pkg::*;
#(
    parameter int AVMM_WIDTH  = AVMM_DATA_W,
    parameter int BYTE_WIDTH  = AVMM_BE_W,
    parameter int CMD_DEPTH   = 4,
    parameter int MAX_RD_PEND = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    // Handshakes: a command moves when cmd_valid & cmd_ready are both high at a
    // rising edge; a bus transfer completes when (read|write) & !waitrequest.
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [AVMM_ADDR_W-1:0] cmd_addr,
    input  logic [BYTE_WIDTH-1:0]  cmd_be,
    input  logic [AVMM_WIDTH-1:0]  cmd_wdata,
    output logic [AVMM_ADDR_W-1:0] avmm_address,
    output logic                   avmm_read,
    output logic                   avmm_write,
    output logic [AVMM_WIDTH-1:0]  avmm_writedata,
    output logic [BYTE_WIDTH-1:0]  avmm_byteenable,
    input  logic                   avmm_waitrequest,
    input  logic [AVMM_WIDTH-1:0]  avmm_readdata,
    input  logic                   avmm_readdatavalid,
    output logic                   rsp_valid,
    output logic [AVMM_WIDTH-1:0]  rsp_data,
    output logic                   rsp_err,
    output logic                   err_unexp,
    output logic                   idle,
    output logic                   dbg_bus_busy
);

    localparam int            TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    avmm_bus_st_e    state_q, state_d;
    avmm_cmd_t       bus_q, bus_d;
    avmm_cmd_t       cmd_in, fifo_head;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [3:0]      rd_pend_q, rd_pend_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_err_q, rsp_err_d;
    logic [AVMM_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic            err_unexp_q, err_unexp_d;
    logic            idle_q, idle_d;
    logic            accept, rd_accept, rd_room, rdv_hit, timeout;

    assign cmd_ready = !fifo_full && !rst;
    assign fifo_push = cmd_valid && cmd_ready;

    always_comb begin
        cmd_in.write = cmd_write;
        cmd_in.addr  = cmd_addr;
        cmd_in.be    = cmd_be;
        cmd_in.wdata = cmd_wdata;
    end

    avmm_cfg_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (cmd_in),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // A read at the head waits for credit, which also stalls everything behind it.
    always_comb begin
        state_d   = state_q;
        bus_d     = bus_q;
        accept    = (state_q == ST_BUSY) && !avmm_waitrequest;
        rd_accept = accept && !bus_q.write;
        rd_room   = (5'(rd_pend_q) + 5'(rd_accept)) < 5'(MAX_RD_PEND);
        fifo_pop  = ((state_q == ST_IDLE) || accept) && !fifo_empty &&
                    (fifo_head.write || rd_room);
        if (fifo_pop) begin
            state_d = ST_BUSY;
            bus_d   = fifo_head;
        end else if (accept) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        rdv_hit     = avmm_readdatavalid && (rd_pend_q != '0);
        timeout     = (rd_pend_q != '0) && !avmm_readdatavalid && (to_cnt_q == TO_LAST);
        rd_pend_d   = rd_pend_q;
        if (rd_accept && !(rdv_hit || timeout)) begin
            rd_pend_d = rd_pend_q + 4'd1;
        end else if (!rd_accept && (rdv_hit || timeout)) begin
            rd_pend_d = rd_pend_q - 4'd1;
        end
        to_cnt_d = to_cnt_q + TW'(1);
        if ((rd_pend_q == '0) || avmm_readdatavalid || timeout) to_cnt_d = '0;
        rsp_valid_d = rdv_hit || timeout;
        rsp_err_d   = timeout;
        rsp_data_d  = rdv_hit ? avmm_readdata : '0;
        err_unexp_d = err_unexp_q || (avmm_readdatavalid && (rd_pend_q == '0));
        idle_d      = fifo_empty && (state_q == ST_IDLE) && (rd_pend_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_q       <= '0;
            rd_pend_q   <= '0;
            to_cnt_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            err_unexp_q <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            rd_pend_q   <= rd_pend_d;
            to_cnt_q    <= to_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            err_unexp_q <= err_unexp_d;
            idle_q      <= idle_d;
        end
    end

    assign avmm_address    = bus_q.addr;
    assign avmm_writedata  = bus_q.wdata;
    assign avmm_byteenable = bus_q.be;
    assign avmm_read       = (state_q == ST_BUSY) && !bus_q.write;
    assign avmm_write      = (state_q == ST_BUSY) && bus_q.write;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_err         = rsp_err_q;
    assign rsp_data        = rsp_data_q;
    assign err_unexp       = err_unexp_q;
    assign idle            = idle_q;
    assign dbg_bus_busy    = (state_q == ST_BUSY);

endmodule

// File: tb/tb_avmm_cfg_master.sv
// Bench for avmm_cfg_master: directed scenarios plus random traffic against a
// command-level shadow memory and a bus-level slave memory.
`timescale 1ns/1ps
module tb_avmm_cfg_master;

    localparam int TO_CYC = 16;
    localparam int MAX_RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [16:0] cmd_addr = '0;
    logic [3:0]  cmd_be = '0;
    logic [31:0] cmd_wdata = '0;
    logic [16:0] avmm_address;
    logic        avmm_read, avmm_write;
    logic [31:0] avmm_writedata;
    logic [3:0]  avmm_byteenable;
    logic        avmm_waitrequest = 1'b0;
    logic [31:0] avmm_readdata = '0;
    logic        avmm_readdatavalid = 1'b0;
    logic        rsp_valid, rsp_err, err_unexp, idle, dbg_bus_busy;
    logic [31:0] rsp_data;

    avmm_cfg_master #(
        .AVMM_WIDTH(32), .BYTE_WIDTH(4), .CMD_DEPTH(4),
        .MAX_RD_PEND(MAX_RD), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
        .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
        .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
        .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
        .avmm_readdatavalid(avmm_readdatavalid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .err_unexp(err_unexp), .idle(idle), .dbg_bus_busy(dbg_bus_busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0, n_fail = 0;
    logic [32:0] exp_q[$];
    logic [31:0] shadow [int];
    logic [31:0] smem [int];

    typedef struct { int due; logic [31:0] data; } rd_ent_t;
    typedef struct { int cyc; logic wr; logic [16:0] addr; int ncyc; bit chg; } acc_t;
    rd_ent_t rd_q[$];
    acc_t    acc_log[$];

    int  rdv_credits = -1, stall_left = 0, rd_lat_max = 1;
    bit  rand_stall = 0, wr_force = 0, force_rdv = 0, slave_flush = 0, both_seen = 0;
    int  outstanding = 0, max_out = 0, last_rsp_cyc = -1, n_rsp = 0, push_negcyc = 0;
    int  cur_ncyc = 0;
    bit  cur_chg = 0;
    logic [54:0] prev_bus = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = nw[8*b +: 8];
        return old;
    endfunction

    // ---------------- slave model (bus level) ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (slave_flush) begin
                rd_q.delete(); outstanding = 0; cur_ncyc = 0; cur_chg = 0; slave_flush = 0;
            end
            avmm_readdatavalid = 1'b0;
            avmm_readdata      = $urandom;
            if (force_rdv) begin
                avmm_readdatavalid = 1'b1;
                force_rdv = 0;
            end else if (rd_q.size() > 0 && cyc >= rd_q[0].due && rdv_credits != 0) begin
                avmm_readdatavalid = 1'b1;
                avmm_readdata      = rd_q[0].data;
                void'(rd_q.pop_front());
                outstanding--;
                if (rdv_credits > 0) rdv_credits--;
            end
            if (wr_force) avmm_waitrequest = 1'b1;
            else if ((avmm_read || avmm_write) && stall_left > 0) begin
                avmm_waitrequest = 1'b1;
                stall_left--;
            end else avmm_waitrequest = rand_stall && ($urandom_range(0, 2) == 0);
            if (avmm_read && avmm_write) both_seen = 1;
            if (rst) begin
                cur_ncyc = 0; cur_chg = 0;
            end else if (avmm_read || avmm_write) begin
                if (cur_ncyc > 0 &&
                    prev_bus != {avmm_read, avmm_write, avmm_address, avmm_writedata, avmm_byteenable})
                    cur_chg = 1;
                prev_bus = {avmm_read, avmm_write, avmm_address, avmm_writedata, avmm_byteenable};
                cur_ncyc++;
                if (!avmm_waitrequest) begin
                    acc_t e;
                    rd_ent_t r;
                    e.cyc = cyc; e.wr = avmm_write; e.addr = avmm_address;
                    e.ncyc = cur_ncyc; e.chg = cur_chg;
                    acc_log.push_back(e);
                    if (avmm_write) begin
                        smem[int'(avmm_address)] = merge(smem.exists(int'(avmm_address)) ?
                            smem[int'(avmm_address)] : 32'h0, avmm_writedata, avmm_byteenable);
                    end else begin
                        r.due  = cyc + $urandom_range(1, rd_lat_max);
                        r.data = smem.exists(int'(avmm_address)) ? smem[int'(avmm_address)] : 32'h0;
                        rd_q.push_back(r);
                        outstanding++;
                        if (outstanding > max_out) max_out = outstanding;
                    end
                    cur_ncyc = 0; cur_chg = 0;
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                n_rsp++;
                last_rsp_cyc = cyc;
                if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
                else check("rsp", {31'h0, rsp_err, rsp_data}, {31'h0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic push_cmd(input logic wr, input logic [16:0] a, input logic [3:0] be,
                            input logic [31:0] d, input int budget, output bit ok);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_be = be; cmd_wdata = d;
        while (!cmd_ready && n < budget) begin
            tick(1);
            n++;
        end
        ok = cmd_ready;
        if (!ok) begin
            cmd_valid = 1'b0;
            return;
        end
        push_negcyc = cyc;
        if (wr) shadow[int'(a)] = merge(shadow.exists(int'(a)) ? shadow[int'(a)] : 32'h0, d, be);
        else exp_q.push_back({1'b0, shadow.exists(int'(a)) ? shadow[int'(a)] : 32'h0});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        tick(1);
    endtask

    task automatic push_ok(input logic wr, input logic [16:0] a, input logic [3:0] be,
                           input logic [31:0] d);
        bit ok;
        push_cmd(wr, a, be, d, 60, ok);
        if (!ok) check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        tick(3);
        while (!(idle && exp_q.size() == 0 && rd_q.size() == 0 && !avmm_read && !avmm_write)
               && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) check("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    function automatic int count_reads();
        int c = 0;
        foreach (acc_log[i]) if (!acc_log[i].wr) c++;
        return c;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int p0, s, n0, n;
        bit ok;

        tick(3);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_read", avmm_read, 0);
        check("rst_write", avmm_write, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_err_unexp", err_unexp, 0);
        rst = 1'b0;
        tick(2);
        check("post_rst_idle", idle, 1);
        check("post_rst_cmd_ready", cmd_ready, 1);

        // 1: zero-wait write then read
        acc_log.delete();
        push_ok(1'b1, 17'h00010, 4'hF, 32'hDEADBEEF);
        p0 = push_negcyc;
        push_ok(1'b0, 17'h00010, 4'hF, 32'h0);
        wait_idle(100);
        check("t1_n_acc", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            check("t1_wr_first", acc_log[0].wr, 1);
            check("t1_wr_addr", acc_log[0].addr, 17'h00010);
            check("t1_latency", acc_log[0].cyc, p0 + 2);
            check("t1_rd_second", acc_log[1].wr, 0);
            check("t1_back_to_back", acc_log[1].cyc, acc_log[0].cyc + 1);
        end
        check("t1_idle", idle, 1);

        // 2: five wait states on a write to the top address
        acc_log.delete();
        stall_left = 5;
        push_ok(1'b1, 17'h1FFFF, 4'hA, 32'h12345678);
        wait_idle(100);
        check("t2_n_acc", acc_log.size(), 1);
        if (acc_log.size() == 1) begin
            check("t2_addr", acc_log[0].addr, 17'h1FFFF);
            check("t2_strobe_cycles", acc_log[0].ncyc, 6);
            check("t2_fields_stable", acc_log[0].chg, 0);
        end

        // 3: read credit limit with readdatavalid withheld
        for (int i = 0; i < 6; i++) push_ok(1'b1, 17'h100 + 17'(i), 4'hF, $urandom);
        wait_idle(100);
        acc_log.delete();
        max_out = 0;
        rdv_credits = 0;
        for (int i = 0; i < 6; i++) push_ok(1'b0, 17'h100 + 17'(i), 4'hF, 32'h0);
        tick(4);
        check("t3_reads_issued", count_reads(), 4);
        check("t3_outstanding", outstanding, 4);
        for (int i = 0; i < 2; i++) begin
            rdv_credits = 1;
            tick(4);
            check("t3_release", count_reads(), 5 + i);
        end
        rdv_credits = -1;
        wait_idle(100);
        check("t3_max_outstanding", max_out, MAX_RD);
        if (acc_log.size() == 6)
            for (int i = 0; i < 6; i++) check("t3_order", acc_log[i].addr, 17'h100 + 17'(i));

        // 4: slave never answers -> timeout response
        acc_log.delete();
        rdv_credits = 0;
        n0 = n_rsp;
        push_ok(1'b0, 17'h00100, 4'hF, 32'h0);
        void'(exp_q.pop_back());
        exp_q.push_back({1'b1, 32'h0});
        n = 0;
        while (n_rsp == n0 && n < 40) begin
            tick(1);
            n++;
        end
        check("t4_rsp_seen", n_rsp - n0, 1);
        if (acc_log.size() == 1) check("t4_timeout_cycle", last_rsp_cyc, acc_log[0].cyc + 17);
        else check("t4_n_acc", acc_log.size(), 1);
        slave_flush = 1;
        rdv_credits = -1;
        tick(3);
        check("t4_idle", idle, 1);

        // 5: FIFO full under stall, then unexpected readdatavalid
        acc_log.delete();
        wr_force = 1;
        for (int i = 0; i < 5; i++) push_ok(1'b1, 17'h200 + 17'(i), 4'hF, $urandom);
        check("t5_cmd_ready_full", cmd_ready, 0);
        push_cmd(1'b1, 17'h205, 4'hF, 32'h0, 4, ok);
        check("t5_push_refused", ok, 0);
        wr_force = 0;
        push_ok(1'b0, 17'h00203, 4'hF, 32'h0);
        wait_idle(200);
        check("t5_n_acc", acc_log.size(), 6);
        check("t5_err_unexp_clear", err_unexp, 0);
        force_rdv = 1;
        tick(3);
        check("t5_err_unexp_set", err_unexp, 1);
        tick(3);
        check("t5_err_unexp_sticky", err_unexp, 1);

        // 6: reset in the middle of a stall with three queued
        wr_force = 1;
        n0 = n_rsp;
        for (int i = 0; i < 4; i++) push_ok(1'b0, 17'h300 + 17'(i), 4'hF, 32'h0);
        tick(2);
        check("t6_stalled_read", avmm_read, 1);
        check("t6_busy", dbg_bus_busy, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_async_read", avmm_read, 0);
        check("t6_async_write", avmm_write, 0);
        check("t6_async_cmd_ready", cmd_ready, 0);
        exp_q.delete();
        slave_flush = 1;
        wr_force = 0;
        acc_log.delete();
        tick(2);
        rst = 1'b0;
        tick(4);
        check("t6_idle", idle, 1);
        check("t6_not_busy", dbg_bus_busy, 0);
        check("t6_no_transfers", acc_log.size(), 0);
        check("t6_no_responses", n_rsp - n0, 0);
        check("t6_err_unexp_reset", err_unexp, 0);

        // random traffic
        rand_stall = 1;
        rd_lat_max = 4;
        max_out = 0;
        for (int i = 0; i < 80; i++) begin
            push_ok(1'($urandom_range(0, 1)), 17'h300 + 17'($urandom_range(0, 7)),
                    4'($urandom_range(0, 15)), $urandom);
            n = $urandom_range(0, 2);
            if (n > 0) tick(n);
        end
        wait_idle(600);
        rand_stall = 0;
        check("rand_drained", exp_q.size(), 0);
        check("rand_max_outstanding_ok", max_out <= MAX_RD, 1);
        check("rand_err_unexp", err_unexp, 0);
        check("never_read_and_write", both_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
